// File: rtl/user_gpio_pkg.sv
// Shared definitions for the user GPIO Wishbone controller: register map,
// reset values and the byte-lane merge helper.
package user_gpio_pkg;

    localparam logic [7:0] REG_OUT  = 8'h00;
    localparam logic [7:0] REG_OEB  = 8'h04;
    localparam logic [7:0] REG_IN   = 8'h08;
    localparam logic [7:0] REG_EDGE = 8'h0C;
    localparam logic [7:0] REG_EN   = 8'h10;
    localparam logic [7:0] REG_STAT = 8'h14;
    localparam logic [7:0] REG_OVF  = 8'h18;

    localparam logic [31:0] RST_OUT  = 32'h0000_0000;
    localparam logic [31:0] RST_OEB  = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_EDGE = 32'h0000_0000;
    localparam logic [31:0] RST_EN   = 32'h0000_0000;

    // Lane n of the result comes from new_v when sel[n] is set, else from old_v.
    function automatic logic [31:0] wb_bytemask(input logic [3:0]  sel,
                                                input logic [31:0] old_v,
                                                input logic [31:0] new_v);
        logic [31:0] res;
        res = old_v;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) res[n*8 +: 8] = new_v[n*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Pad-input synchroniser with a trailing prev flop; reports the selected
// edge (rising or falling per pin) as a single-cycle pulse.
module gpio_edge_sync #(
    parameter int W   = 27,
    parameter int STG = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_pin,
    input  logic [W-1:0] i_edge_sel,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_edge
);

    logic [W-1:0] r_sync [STG];
    logic [W-1:0] r_prev;
    logic [W-1:0] w_rise;
    logic [W-1:0] w_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STG; k++) r_sync[k] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int k = 1; k < STG; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[STG-1];
        end
    end

    // Detection looks only at sync/prev, so flipping the sense on a static pin is silent.
    assign w_rise = r_sync[STG-1] & ~r_prev;
    assign w_fall = ~r_sync[STG-1] & r_prev;
    assign o_sync = r_sync[STG-1];
    assign o_edge = (w_rise & ~i_edge_sel) | (w_fall & i_edge_sel);

endmodule

// File: rtl/user_gpio_wb_ctrl.sv
// Wishbone register slave for the user GPIOs: output/enable registers,
// synchronised input readback, sticky edge flags and interrupt reduction.
module user_gpio_wb_ctrl
    import user_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NGPIO     = 27,
    parameter int          SYNC_STG  = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NGPIO-1:0] io_in,
    output logic [NGPIO-1:0] io_out,
    output logic [NGPIO-1:0] io_oeb,
    output logic [2:0]       user_irq
);

    logic [NGPIO-1:0] r_out, r_oeb, r_edge, r_en, r_stat, r_ovf;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic [2:0]       r_irq;

    logic             w_hit, w_req, w_wr;
    logic [7:0]       w_off;
    logic [31:0]      w_rdata;
    logic [31:0]      w_se;
    logic [NGPIO-1:0] w_sync, w_edge, w_stat_clr, w_ovf_clr;

    function automatic logic [31:0] ext(input logic [NGPIO-1:0] v);
        logic [31:0] res;
        res = '0;
        res[NGPIO-1:0] = v;
        return res;
    endfunction

    gpio_edge_sync #(.W(NGPIO), .STG(SYNC_STG)) u_sync (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_pin      (io_in),
        .i_edge_sel (r_edge),
        .o_sync     (w_sync),
        .o_edge     (w_edge)
    );

    // A request is never raised while ack is high, so a held strobe takes two cycles per access.
    assign w_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_req = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_wr  = w_req & wbs_we_i;
    assign w_off = wbs_adr_i[7:0] & 8'hFC;

    assign w_stat_clr = (w_wr && w_off == REG_STAT) ?
                        NGPIO'(wb_bytemask(wbs_sel_i, 32'h0, wbs_dat_i)) : '0;
    assign w_ovf_clr  = (w_wr && w_off == REG_OVF) ?
                        NGPIO'(wb_bytemask(wbs_sel_i, 32'h0, wbs_dat_i)) : '0;
    assign w_se       = ext(r_stat & r_en);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_OUT:  w_rdata = ext(r_out);
            REG_OEB:  w_rdata = ext(r_oeb);
            REG_IN:   w_rdata = ext(w_sync);
            REG_EDGE: w_rdata = ext(r_edge);
            REG_EN:   w_rdata = ext(r_en);
            REG_STAT: w_rdata = ext(r_stat);
            REG_OVF:  w_rdata = ext(r_ovf);
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out  <= NGPIO'(RST_OUT);
            r_oeb  <= NGPIO'(RST_OEB);
            r_edge <= NGPIO'(RST_EDGE);
            r_en   <= NGPIO'(RST_EN);
            r_stat <= '0;
            r_ovf  <= '0;
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_irq  <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
            if (w_wr) begin
                case (w_off)
                    REG_OUT:  r_out  <= NGPIO'(wb_bytemask(wbs_sel_i, ext(r_out), wbs_dat_i));
                    REG_OEB:  r_oeb  <= NGPIO'(wb_bytemask(wbs_sel_i, ext(r_oeb), wbs_dat_i));
                    REG_EDGE: r_edge <= NGPIO'(wb_bytemask(wbs_sel_i, ext(r_edge), wbs_dat_i));
                    REG_EN:   r_en   <= NGPIO'(wb_bytemask(wbs_sel_i, ext(r_en), wbs_dat_i));
                    default:  ;
                endcase
            end
            // New edges are OR-ed in after the clear, so a same-cycle set beats W1C.
            r_stat <= (r_stat & ~w_stat_clr) | w_edge;
            r_ovf  <= (r_ovf & ~w_ovf_clr) | (w_edge & r_stat);
            r_irq  <= {|r_ovf, |w_se[31:14], |w_se[13:0]};
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_out;
    assign io_oeb    = r_oeb;
    assign user_irq  = r_irq;

endmodule

// File: tb/tb_user_gpio_wb_ctrl.sv
// Directed bench for user_gpio_wb_ctrl: register access, byte lanes,
// edge flags, overflow, set-vs-clear priority, decode misses and reset.
module tb_user_gpio_wb_ctrl;

    localparam int          NGPIO = 27;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic             wbs_stb_i = 1'b0;
    logic             wbs_cyc_i = 1'b0;
    logic             wbs_we_i = 1'b0;
    logic [3:0]       wbs_sel_i = 4'h0;
    logic [31:0]      wbs_dat_i = '0;
    logic [31:0]      wbs_adr_i = '0;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [NGPIO-1:0] io_in = '0;
    logic [NGPIO-1:0] io_out;
    logic [NGPIO-1:0] io_oeb;
    logic [2:0]       user_irq;

    int n_tests = 0;
    int n_fail  = 0;

    user_gpio_wb_ctrl #(.BASE_ADDR(BASE), .NGPIO(NGPIO), .SYNC_STG(2)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    // Callers sit #1 after a rising edge; the access ends with one idle cycle so ack is low again.
    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bit got;
        got = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = addr; wbs_dat_i = data; wbs_sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i);
            #1;
            got = wbs_ack_o;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check($sformatf("wr_ack_%h", addr), 32'(got), 32'd1);
        tick(1);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        data = 32'hDEAD_BEEF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = addr; wbs_sel_i = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i);
            #1;
            lat++;
            got = wbs_ack_o;
        end
        if (got) data = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick(1);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int lat;
        wb_read(addr, d, lat);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          miss_acks;

        // Reset
        tick(3);
        wb_rst_i = 1'b0;
        check("rst_io_oeb", 32'(io_oeb), 32'h07FF_FFFF);
        check("rst_io_out", 32'(io_out), 32'h0);
        check("rst_irq", 32'(user_irq), 32'h0);
        check("rst_ack", 32'(wbs_ack_o), 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);

        // 1: first read, one-cycle latency, ack a single pulse
        wb_read(BASE + 32'h04, d, lat);
        check("oeb_read", d, 32'h07FF_FFFF);
        check("oeb_latency", 32'(lat), 32'd1);
        check("ack_pulse_low", 32'(wbs_ack_o), 32'h0);
        check("dat_idle_zero", wbs_dat_o, 32'h0);

        // 2: byte-lane writes
        wb_write(BASE + 32'h00, 32'h0000_00A5, 4'b0001);
        check("out_lane0", 32'(io_out), 32'h0000_00A5);
        wb_write(BASE + 32'h00, 32'h0000_FF00, 4'b0010);
        check("out_lane1", 32'(io_out), 32'h0000_FFA5);
        rd_check("out_read", BASE + 32'h00, 32'h0000_FFA5);
        wb_write(BASE + 32'h00, 32'h1234_5678, 4'b1000);
        check("out_lane3_trunc", 32'(io_out), 32'h0200_FFA5);
        rd_check("out_read_trunc", BASE + 32'h00, 32'h0200_FFA5);
        wb_write(BASE + 32'h04, 32'h0000_0F0F, 4'b1111);
        check("oeb_write", 32'(io_oeb), 32'h0000_0F0F);
        rd_check("reserved_1c", BASE + 32'h1C, 32'h0);
        wb_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'b1111);
        rd_check("reserved_20", BASE + 32'h20, 32'h0);

        // 3: rising edge on pin 3, irq timing, W1C
        wb_write(BASE + 32'h10, 32'h0000_0008, 4'b1111);
        io_in[3] = 1'b1;
        tick(2);
        check("irq_p3_c2", 32'(user_irq), 32'h0);
        tick(1);
        check("irq_p3_c3", 32'(user_irq), 32'h0);
        tick(1);
        check("irq_p3_c4", 32'(user_irq), 32'h1);
        rd_check("stat_p3", BASE + 32'h14, 32'h0000_0008);
        wb_write(BASE + 32'h14, 32'h0000_0008, 4'b1111);
        check("irq_p3_cleared", 32'(user_irq), 32'h0);
        rd_check("stat_p3_cleared", BASE + 32'h14, 32'h0);

        // 4: overflow on pin 20
        io_in[20] = 1'b1;
        tick(4);
        io_in[20] = 1'b0;
        tick(3);
        io_in[20] = 1'b1;
        tick(4);
        check("irq_ovf", 32'(user_irq), 32'h4);
        rd_check("ovf_p20", BASE + 32'h18, 32'h0010_0000);
        rd_check("stat_p20", BASE + 32'h14, 32'h0010_0000);
        wb_write(BASE + 32'h10, 32'h0010_0008, 4'b1111);
        check("irq_bank1", 32'(user_irq), 32'h6);
        wb_write(BASE + 32'h18, 32'h0010_0000, 4'b1111);
        check("irq_ovf_cleared", 32'(user_irq), 32'h2);
        rd_check("ovf_cleared", BASE + 32'h18, 32'h0);
        wb_write(BASE + 32'h14, 32'h0010_0000, 4'b1111);
        check("irq_all_cleared", 32'(user_irq), 32'h0);

        // Falling-edge sense on pin 7; changing the sense on a static pin is silent
        wb_write(BASE + 32'h0C, 32'h0000_0080, 4'b1111);
        io_in[7] = 1'b1;
        tick(4);
        rd_check("stat_p7_rise_ignored", BASE + 32'h14, 32'h0);
        io_in[7] = 1'b0;
        tick(4);
        rd_check("stat_p7_fall", BASE + 32'h14, 32'h0000_0080);
        wb_write(BASE + 32'h14, 32'h0000_0080, 4'b1111);

        // 5: edge on pin 5 lands on the same edge as its W1C
        io_in[5] = 1'b1;
        tick(2);
        wb_write(BASE + 32'h14, 32'h0000_0020, 4'b1111);
        rd_check("stat_p5_set_wins", BASE + 32'h14, 32'h0000_0020);
        rd_check("ovf_p5_none", BASE + 32'h18, 32'h0);
        wb_write(BASE + 32'h14, 32'h0000_0020, 4'b1111);
        rd_check("stat_p5_cleared", BASE + 32'h14, 32'h0);

        // IN readback
        io_in = 27'h4A5_1234;
        tick(3);
        rd_check("in_read", BASE + 32'h08, 32'h04A5_1234);

        // 6: decode miss
        io_in = '0;
        miss_acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0100;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (wbs_ack_o) miss_acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("miss_no_ack", 32'(miss_acks), 32'd0);
        tick(1);

        // Reset in the middle of a held read
        wb_write(BASE + 32'h00, 32'h0000_0155, 4'b1111);
        wb_write(BASE + 32'h0C, 32'h0000_0003, 4'b1111);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h00;
        tick(1);
        check("ack_before_rst", 32'(wbs_ack_o), 32'h1);
        wb_rst_i = 1'b1;
        tick(1);
        check("rst_mid_ack", 32'(wbs_ack_o), 32'h0);
        check("rst_mid_dat", wbs_dat_o, 32'h0);
        check("rst_mid_out", 32'(io_out), 32'h0);
        check("rst_mid_oeb", 32'(io_oeb), 32'h07FF_FFFF);
        check("rst_mid_irq", 32'(user_irq), 32'h0);
        tick(1);
        check("rst_held_ack", 32'(wbs_ack_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        wb_rst_i = 1'b0;
        tick(1);
        rd_check("post_rst_out", BASE + 32'h00, 32'h0);
        rd_check("post_rst_oeb", BASE + 32'h04, 32'h07FF_FFFF);
        rd_check("post_rst_edge", BASE + 32'h0C, 32'h0);
        rd_check("post_rst_en", BASE + 32'h10, 32'h0);
        rd_check("post_rst_stat", BASE + 32'h14, 32'h0);
        rd_check("post_rst_ovf", BASE + 32'h18, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
